imm_encoder: RTL
================

# imm_encoder

Pipelined RISC-V instruction encoder: the inverse of the immediate-extension path. Accepts an instruction format selector, a 32-bit signed immediate and register/opcode fields, and scatters the immediate into the I/S/B/J bit positions to produce a 32-bit instruction word. Used by the program-loader/self-test path to build instruction words in hardware. Two-stage valid/ready pipeline with backpressure, an optional immediate range checker and a saturating error counter.

## Interface
- ERR_W, 8, width of the saturating error counter
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  encoder can accept a beat
- immsrc  input  2  format: 00 I, 01 S, 10 B, 11 J
- imm  input  32  signed immediate, byte offset for B/J
- opcode  input  7  instr[6:0]
- funct3  input  3  instr[14:12] (I/S/B; ignored for J)
- rd  input  5  instr[11:7] (I/J only)
- rs1  input  5  instr[19:15] (I/S/B only)
- rs2  input  5  instr[24:20] (S/B only)
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts word
- instr  output  32  encoded instruction
- out_err  output  1  immediate not representable (qualified by out_valid)
- err_count  output  ERR_W  count of errored words delivered, saturating

## Operation
- Field placement: I: instr[31:20]=imm[11:0]. S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]. B: instr[31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]. Unused field bits driven 0.
- Representability: I/S: imm[31:11] all equal. B: imm[31:12] all equal and imm[0]=0. J: imm[31:20] all equal and imm[0]=0.
- Non-representable imm: word still emitted with low bits truncated per placement, out_err=1.
- Stage 1 (S1) registers encoded word + err on input handshake (in_valid && in_ready). Stage 2 (S2) is the output register driving instr/out_valid/out_err.
- S1→S2 transfer when S1 valid and (S2 empty or out_ready). in_ready = !S1_valid || S2 empty || out_ready (combinational from out_ready; no combinational path from in_valid to out_valid).
- err_count increments on each output handshake with out_err=1; holds at 2^ERR_W-1.
- Order strictly preserved; no beat dropped or duplicated.

## Timing
- Reset (async assert, sync release): S1/S2 empty, out_valid=0, instr=0, out_err=0, err_count=0, in_ready=1 after reset.
- Latency: beat accepted at edge N appears on out_valid after edge N+1 (2-cycle pipeline, visible in cycle N+2 window).
- Throughput: 1 beat/cycle with out_ready=1.
- out_ready=0 with both stages full: in_ready=0; instr/out_err held stable while out_valid=1 and !out_ready.
- Simultaneous output handshake and input handshake when full: S2←S1, S1←input same edge.
- Reset mid-operation: in-flight beats discarded, err_count cleared.

## Configuration
- IMM_RANGE_CHECK_EN defined: representability check active, out_err and err_count as above.
- Not defined: no check logic; out_err tied 0, err_count tied 0; field placement and handshake unchanged.

## Test plan
- I: immsrc=00, imm=0xFFFFFFFF, rd=5, rs1=6, funct3=0, opcode=0x13 -> instr=0xFFF30293, out_err=0, two cycles after accept.
- S: immsrc=01, imm=8, rs1=1, rs2=2, funct3=2, opcode=0x23 -> 0x0020A423; B: immsrc=10, imm=0xFFFFFFFC, rs1=rs2=0, funct3=0, opcode=0x63 -> 0xFE000EE3.
- J: immsrc=11, imm=0x800, rd=1, opcode=0x6F -> 0x001000EF; back-to-back with out_ready=1 -> one word per cycle, in order.
- Errors (macro on): I imm=2048 -> instr[31:20]=0x800, out_err=1; B imm=3 -> out_err=1; err_count=2; with ERR_W=2, five errored words -> err_count=3. Macro off: same stimulus -> out_err=0, err_count=0.
- Backpressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0, instr stable; out_ready=1 -> all 3 delivered in order. Assert rst_n=0 mid-stream -> out_valid=0 immediately, counter=0.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder
//   Two-stage valid/ready pipeline that builds a RISC-V instruction word
//   from a format selector, a 32-bit signed immediate and the register /
//   opcode fields. The immediate is scattered into the I/S/B/J bit positions.
//   Stage 1 holds the freshly encoded word. Stage 2 is the output register.
//
// Optional feature: define IMM_RANGE_CHECK_EN to enable the immediate
//   representability check. This drives out_err and the saturating
//   err_count. When the macro is undefined, out_err and err_count are tied to 0.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  input handshake
//   immsrc               format select: 00 I, 01 S, 10 B, 11 J
//   imm                  signed immediate (byte offset for B/J)
//   opcode, funct3, rd, rs1, rs2   instruction fields
//   out_valid / out_ready          output handshake
//   instr                encoded instruction word
//   out_err              immediate not representable (qualified by out_valid)
//   err_count            saturating count of errored words delivered
module imm_encoder #(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       immsrc,
  input  logic [31:0]      imm,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  logic [31:0] enc_word;

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_instr_q, s1_instr_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;

  logic s2_free, in_fire, s1_to_s2, out_fire;

  // Field scatter. Fields that a format does not use are driven to zero.
  always_comb begin
    enc_word = '0;
    unique case (immsrc)
      2'b00: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      2'b01: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      2'b10: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                         imm[4:1], imm[11], opcode};
      2'b11: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_word = '0;
    endcase
  end

  // Stage 2 can take a word if it is empty or is draining this cycle.
  // in_ready depends on out_ready, but not on in_valid.
  assign s2_free  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign s1_to_s2 = s1_valid_q && s2_free;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;

    if (s1_to_s2) begin
      s2_valid_d = 1'b1;
      s2_instr_d = s1_instr_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_instr_d = enc_word;
    end else if (s1_to_s2) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign instr     = s2_instr_q;

`ifdef IMM_RANGE_CHECK_EN
  logic             enc_err;
  logic             s1_err_q, s1_err_d;
  logic             s2_err_q, s2_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  // The immediate fits if every bit above the top encodable bit matches the
  // sign bit. B and J immediates must also be even.
  always_comb begin
    enc_err = 1'b0;
    unique case (immsrc)
      2'b00, 2'b01: enc_err = (imm[31:11] != {21{imm[31]}});
      2'b10:        enc_err = (imm[31:12] != {20{imm[31]}}) || imm[0];
      2'b11:        enc_err = (imm[31:20] != {12{imm[31]}}) || imm[0];
      default:      enc_err = 1'b0;
    endcase
  end

  always_comb begin
    s1_err_d  = s1_err_q;
    s2_err_d  = s2_err_q;
    err_cnt_d = err_cnt_q;
    if (s1_to_s2) s2_err_d = s1_err_q;
    if (in_fire)  s1_err_d = enc_err;
    if (out_fire && s2_err_q && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err_q  <= 1'b0;
      s2_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      s1_err_q  <= s1_err_d;
      s2_err_q  <= s2_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_err   = s2_err_q;
  assign err_count = err_cnt_q;
`else
  // Without the range check the upper immediate bits are never consumed.
  // In that build, out_fire has no consumer either.
  logic unused_imm_hi;
  assign unused_imm_hi = ^{imm[31:21], out_fire};
  assign out_err       = 1'b0;
  assign err_count     = '0;
`endif

endmodule
